// File: rtl/nn_train_sequencer_if.sv
// nn_train_sequencer_if: control/status bundle between the training sequencer and its host.
interface nn_train_sequencer_if #(
   parameter int LOSS_W  = 46,
   parameter int EPOCH_W = 8
);
   logic              en_i;
   logic              init_i;
   logic              abort_i;
   logic [LOSS_W-1:0] loss_i;
   logic [LOSS_W-1:0] loss_thresh_i;
   logic              f0_pass_o;
   logic              f1_pass_o;
   logic              b_pass_o;
   logic              w_upd_o;
   logic [EPOCH_W-1:0] epoch_o;
   logic              busy_o;
   logic              done_o;
   logic              converged_o;
   modport master (
      output en_i, init_i, abort_i, loss_i, loss_thresh_i,
      input  f0_pass_o, f1_pass_o, b_pass_o, w_upd_o, epoch_o, busy_o, done_o, converged_o
   );
   modport slave (
      input  en_i, init_i, abort_i, loss_i, loss_thresh_i,
      output f0_pass_o, f1_pass_o, b_pass_o, w_upd_o, epoch_o, busy_o, done_o, converged_o
   );
endinterface

// File: rtl/nn_train_sequencer.sv
// nn_train_sequencer: epoch sequencer for the 4-8-1 array (forward, loss check, backward, update).
module nn_train_sequencer #(
   parameter int HID_LAT   = 2,
   parameter int OUT_LAT   = 3,
   parameter int BP_LAT    = 4,
   parameter int LOSS_W    = 46,
   parameter int EPOCH_W   = 8,
   parameter int MAX_EPOCH = 200
) (
   input  logic clk_i,
   input  logic rst_i,
   nn_train_sequencer_if.slave bus
);
   localparam int MAX_LAT = (HID_LAT > OUT_LAT) ? ((HID_LAT > BP_LAT) ? HID_LAT : BP_LAT)
                                                : ((OUT_LAT > BP_LAT) ? OUT_LAT : BP_LAT);
   localparam int CW = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

   typedef enum logic [2:0] {IDLE, F0, F1, CHECK, BP, UPD, DONE} state_t;

   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [EPOCH_W-1:0] epoch_q, epoch_d;
   logic               conv_q, conv_d;
   logic               f0_q, f1_q, b_q, w_q, busy_q, done_q;

   // Phase counter restarts at 0 on every state entry, so it only advances while a phase stays put.
   always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      epoch_d = epoch_q;
      conv_d  = conv_q;
      if (bus.abort_i) begin
         state_d = IDLE;
         epoch_d = '0;
         conv_d  = 1'b0;
      end else begin
         unique case (state_q)
            IDLE: if (bus.init_i) begin
               state_d = F0;
               epoch_d = '0;
               conv_d  = 1'b0;
            end
            F0: if (cnt_q == CW'(HID_LAT - 1)) state_d = F1;
                else cnt_d = cnt_q + CW'(1);
            F1: if (cnt_q == CW'(OUT_LAT - 1)) state_d = CHECK;
                else cnt_d = cnt_q + CW'(1);
            CHECK: if (bus.loss_i <= bus.loss_thresh_i) begin
               state_d = DONE;
               conv_d  = 1'b1;
            end else if (epoch_q == EPOCH_W'(MAX_EPOCH - 1)) begin
               state_d = DONE;
               conv_d  = 1'b0;
            end else state_d = BP;
            BP: if (cnt_q == CW'(BP_LAT - 1)) state_d = UPD;
                else cnt_d = cnt_q + CW'(1);
            UPD: begin
               state_d = F0;
               epoch_d = epoch_q + EPOCH_W'(1);
            end
            DONE: if (!bus.init_i) state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         epoch_q <= '0;
         conv_q  <= 1'b0;
         f0_q    <= 1'b0;
         f1_q    <= 1'b0;
         b_q     <= 1'b0;
         w_q     <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else if (bus.en_i) begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         epoch_q <= epoch_d;
         conv_q  <= conv_d;
         f0_q    <= (state_d == F0);
         f1_q    <= (state_d == F1);
         b_q     <= (state_d == BP);
         w_q     <= (state_d == UPD);
         busy_q  <= !(state_d inside {IDLE, DONE});
         done_q  <= (state_d == DONE);
      end
   end

   assign bus.f0_pass_o   = f0_q;
   assign bus.f1_pass_o   = f1_q;
   assign bus.b_pass_o    = b_q;
   assign bus.w_upd_o     = w_q;
   assign bus.epoch_o     = epoch_q;
   assign bus.busy_o      = busy_q;
   assign bus.done_o      = done_q;
   assign bus.converged_o = conv_q;
endmodule

// File: tb/tb_nn_train_sequencer.sv
// tb_nn_train_sequencer: directed bench for the training sequencer, built with MAX_EPOCH=3.
module tb_nn_train_sequencer;
   logic clk_i = 1'b0;
   logic rst_i = 1'b0;
   int   vectors = 0;
   int   miscompares = 0;
   int   wcnt = 0;
   int   bcnt = 0;
   logic wprev = 1'b0;

   localparam logic [3:0] F0P = 4'b1000, F1P = 4'b0100, BPP = 4'b0010, UPP = 4'b0001, NONE = 4'b0000;
   localparam logic [3:0] EP [11] = '{F0P, F0P, F1P, F1P, F1P, NONE, BPP, BPP, BPP, BPP, UPP};

   nn_train_sequencer_if #(.LOSS_W(46), .EPOCH_W(8)) bus ();

   nn_train_sequencer #(.MAX_EPOCH(3)) dut (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .bus   (bus.slave)
   );

   always #5 clk_i = ~clk_i;

   wire [3:0] pat = {bus.f0_pass_o, bus.f1_pass_o, bus.b_pass_o, bus.w_upd_o};

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
      if (bus.w_upd_o && !wprev) wcnt++;
      wprev = bus.w_upd_o;
      if (bus.b_pass_o) bcnt++;
   endtask

   initial begin
      bus.en_i          = 1'b1;
      bus.init_i        = 1'b1;
      bus.abort_i       = 1'b0;
      bus.loss_i        = 46'd101;
      bus.loss_thresh_i = 46'd100;
      step();
      step();
      chk("rst_pat", pat, NONE);
      chk("rst_epoch", bus.epoch_o, 0);
      chk("rst_busy", bus.busy_o, 0);
      chk("rst_done", bus.done_o, 0);
      chk("rst_conv", bus.converged_o, 0);
      rst_i = 1'b1;
      for (int i = 0; i < 11; i++) begin
         step();
         chk("ep0_pat", pat, EP[i]);
         chk("ep0_busy", bus.busy_o, 1);
         chk("ep0_epoch", bus.epoch_o, 0);
      end
      step();
      chk("ep1_f0", pat, F0P);
      chk("ep1_epoch", bus.epoch_o, 1);
      bus.init_i = 1'b0;
      repeat (3) step();
      chk("ep1_f1c2", pat, F1P);
      bus.en_i = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("stall_f1", pat, F1P);
         chk("stall_epoch", bus.epoch_o, 1);
      end
      bus.en_i = 1'b1;
      step();
      chk("ep1_f1c3", pat, F1P);
      step();
      chk("ep1_check", pat, NONE);
      chk("ep1_check_busy", bus.busy_o, 1);
      for (int i = 0; i < 4; i++) begin
         step();
         chk("ep1_bp", pat, BPP);
      end
      step();
      chk("ep1_upd", pat, UPP);
      bus.en_i = 1'b0;
      for (int i = 0; i < 2; i++) begin
         step();
         chk("stall_upd", pat, UPP);
         chk("stall_upd_epoch", bus.epoch_o, 1);
      end
      bus.en_i = 1'b1;
      step();
      chk("ep2_f0", pat, F0P);
      chk("ep2_epoch", bus.epoch_o, 2);
      step();
      chk("ep2_f0c2", pat, F0P);
      repeat (3) step();
      chk("ep2_f1c3", pat, F1P);
      step();
      chk("ep2_check", pat, NONE);
      step();
      chk("budget_done", bus.done_o, 1);
      chk("budget_conv", bus.converged_o, 0);
      chk("budget_epoch", bus.epoch_o, 2);
      chk("budget_busy", bus.busy_o, 0);
      chk("budget_pat", pat, NONE);
      chk("budget_wupd_pulses", wcnt, 2);
      bus.init_i = 1'b1;
      repeat (3) step();
      chk("done_hold", bus.done_o, 1);
      bus.init_i = 1'b0;
      step();
      chk("idle_done", bus.done_o, 0);
      chk("idle_busy", bus.busy_o, 0);
      chk("idle_epoch_kept", bus.epoch_o, 2);
      bus.loss_i = 46'd100;
      bus.init_i = 1'b1;
      step();
      chk("conv_start", pat, F0P);
      chk("conv_start_epoch", bus.epoch_o, 0);
      bcnt = 0;
      bus.init_i = 1'b0;
      repeat (4) step();
      step();
      chk("conv_check", pat, NONE);
      step();
      chk("conv_done", bus.done_o, 1);
      chk("conv_flag", bus.converged_o, 1);
      chk("conv_epoch", bus.epoch_o, 0);
      chk("conv_no_bp", bcnt, 0);
      step();
      chk("conv_idle", bus.done_o, 0);
      bus.loss_i = 46'd101;
      bus.init_i = 1'b1;
      step();
      chk("ab_start", pat, F0P);
      chk("ab_start_conv", bus.converged_o, 0);
      bus.init_i = 1'b0;
      repeat (10) step();
      chk("ab_upd0", pat, UPP);
      step();
      chk("ab_ep1", bus.epoch_o, 1);
      repeat (8) step();
      chk("ab_bp3", pat, BPP);
      bus.abort_i = 1'b1;
      bus.init_i  = 1'b1;
      step();
      chk("ab_pat", pat, NONE);
      chk("ab_epoch", bus.epoch_o, 0);
      chk("ab_busy", bus.busy_o, 0);
      chk("ab_conv", bus.converged_o, 0);
      bus.abort_i = 1'b0;
      step();
      chk("ab_restart", pat, F0P);
      chk("ab_restart_busy", bus.busy_o, 1);
      bus.init_i = 1'b0;
      repeat (10) step();
      chk("rst_upd", pat, UPP);
      #2;
      rst_i = 1'b0;
      #1;
      chk("arst_wupd", bus.w_upd_o, 0);
      chk("arst_busy", bus.busy_o, 0);
      chk("arst_epoch", bus.epoch_o, 0);
      chk("arst_pat", pat, NONE);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/nn_train_sequencer.md
Name: nn_train_sequencer

Overview:
Top-level training controller for the 4-8-1 neuron array. Sequences forward pass 0 (hidden layer), forward pass 1 (output neuron), the loss/convergence check, the backward pass and the weight-update strobe, and counts epochs until the loss meets a threshold or the epoch budget runs out. It drives the hidden and output neuron enables and the end-check/loss path, and takes over the phase strobes from the state machine that currently generates them.

Parameters:
HID_LAT, 2, cycles f0_pass_o stays high per epoch (>=1)
OUT_LAT, 3, cycles f1_pass_o stays high per epoch (>=1)
BP_LAT, 4, cycles b_pass_o stays high per epoch (>=1)
LOSS_W, 46, loss bus width
EPOCH_W, 8, epoch counter width
MAX_EPOCH, 200, epoch budget (1..2^EPOCH_W-1)

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-low reset
en_i  in  1  global advance enable; low freezes state, counters and outputs
init_i  in  1  start request (level)
abort_i  in  1  synchronous abort to IDLE
loss_i  in  LOSS_W  unsigned loss from output neuron, valid during CHECK
loss_thresh_i  in  LOSS_W  unsigned convergence threshold
f0_pass_o  out  1  hidden-layer forward enable
f1_pass_o  out  1  output-neuron forward enable
b_pass_o  out  1  backward-pass enable
w_upd_o  out  1  one-cycle weight-commit strobe
epoch_o  out  EPOCH_W  completed-epoch count
busy_o  out  1  high in every state except IDLE and DONE
done_o  out  1  high in DONE
converged_o  out  1  in DONE: 1 = threshold met, 0 = budget exhausted

Behaviour:
- Reset (rst_i=0, async): state IDLE, phase counter 0, epoch_o 0, all 1-bit outputs 0. Reset mid-operation aborts the run immediately; there is no resume.
- All outputs are registered and are decoded from the registered state. All transitions below happen only on cycles with en_i=1. When en_i=0, state, phase counter, epoch_o and all outputs hold, including a w_upd_o that is already high.
- abort_i=1 with en_i=1: next state is IDLE, epoch_o clears to 0, converged_o clears to 0. abort_i has priority over every other transition, including init_i in IDLE.
- IDLE: if init_i=1, go to F0, phase counter 0, epoch_o 0.
- F0: f0_pass_o=1 for exactly HID_LAT enabled cycles, then go to F1.
- F1: f1_pass_o=1 for exactly OUT_LAT enabled cycles, then go to CHECK.
- CHECK: one cycle with no strobe. Sample loss_i.
  - If loss_i <= loss_thresh_i (unsigned, full LOSS_W compare): go to DONE with converged_o=1.
  - Else if epoch_o == MAX_EPOCH-1: go to DONE with converged_o=0.
  - Otherwise go to BP.
- BP: b_pass_o=1 for exactly BP_LAT enabled cycles, then go to UPD.
- UPD: w_upd_o=1 for one cycle. epoch_o increments on leaving UPD, then go to F0.
- DONE: done_o=1; epoch_o and converged_o hold. Go to IDLE when init_i=0. A held-high init_i keeps the block in DONE and does not start a new run.
- IDLE after DONE: done_o=0, epoch_o keeps its value until the next start (then clears to 0).
- At most one of f0_pass_o / f1_pass_o / b_pass_o / w_upd_o is high in any cycle.
- Epoch length = HID_LAT+OUT_LAT+1+BP_LAT+1 cycles; 11 cycles with the default parameters.
- epoch_o never wraps: the maximum value reached is MAX_EPOCH-1.
- Phase counter width is clog2 of the largest LAT parameter. The counter resets to 0 on every state entry.

Test Plan:
- Reset with init_i=1 held, then release rst_i -> first cycle F0 (f0_pass_o=1); f0 high for 2 cycles, f1 for 3, one gap cycle, b for 4, w_upd for 1; epoch_o becomes 1 at cycle 11.
- loss_i=100, loss_thresh_i=100 at the first CHECK -> DONE the next cycle, converged_o=1, epoch_o=0, b_pass_o never asserted.
- loss_i=101, loss_thresh_i=100 constant, MAX_EPOCH=3 -> exactly 2 w_upd_o pulses, DONE with converged_o=0, epoch_o=2.
- en_i pulled low for 5 cycles during the second F1 cycle -> f1_pass_o stays high and frozen; total f1 high count = 3 enabled cycles plus the 5 stalled cycles; sequence then resumes unchanged.
- abort_i and init_i both high in the 3rd BP cycle -> IDLE the next cycle, all strobes 0, epoch_o=0; the following cycle with abort_i=0 and init_i=1 -> F0.
- rst_i asserted mid-UPD -> w_upd_o and busy_o drop to 0 immediately (asynchronous), epoch_o=0.
